sram_bus_arbiter: RTL
=====================

// Module: sram_bus_arbiter
// PURPOSE
//  Shares one SRAM-like bus (req/addr_ok/data_ok) between the IF-stage fetch port and the MEM-stage load/store port.
//  Allows one outstanding transaction at a time. Returns read data and a one-cycle done pulse to the owning port.
//  Drives stall_req into the hazard unit, which feeds the stallF..stallW / flushE..flushW nets of controller/datapath.
// PARAMETERS
//  ADDR_W     32  address width on both ports and the bus
//  DATA_W     32  data width on both ports and the bus
//  DATA_PRIO  1   tie-break policy: 1 = data port always wins; 0 = alternate with last owner
// PORTS
//  clk          in   1       pipeline clock
//  rst          in   1       asynchronous, active-low reset
//  inst_req     in   1       fetch request, held until inst_done
//  inst_addr    in   ADDR_W  fetch address (pcF)
//  inst_rdata   out  DATA_W  fetched word, valid while inst_done=1
//  inst_done    out  1       one-cycle completion pulse for fetch
//  data_req     in   1       MEM-stage access request (memenM), held until data_done
//  data_wr      in   1       1 = store (memwriteM)
//  data_size    in   2       0 = byte, 1 = half, 2 = word
//  data_addr    in   ADDR_W  MEM-stage address
//  data_wdata   in   DATA_W  store data, already lane-aligned
//  data_rdata   out  DATA_W  load word, valid while data_done=1
//  data_done    out  1       one-cycle completion pulse for data
//  flush        in   1       exception/eret flush: discard any fetch in flight
//  bus_req      out  1       bus request
//  bus_wr       out  1       bus write
//  bus_size     out  2       bus size
//  bus_addr     out  ADDR_W  bus address
//  bus_wdata    out  DATA_W  bus write data
//  bus_addr_ok  in   1       bus address accepted this cycle
//  bus_data_ok  in   1       bus read data / write ack this cycle
//  bus_rdata    in   DATA_W  bus read data
//  stall_req    out  1       = (inst_req & ~inst_done) | (data_req & ~data_done)
// BEHAVIOUR
//  Reset (rst=0, asynchronous):
//   - state=IDLE, owner=INST, last_owner=INST, discard=0.
//   - All bus_* outputs, *_rdata and *_done are 0.
//  FSM states IDLE, ADDR, DATA (registered). All bus_* outputs come from registers.
//  IDLE:
//   - Pick an owner from the pending requests and latch wr/size/addr/wdata.
//   - Go to ADDR. If no request is pending, stay in IDLE.
//  ADDR:
//   - bus_req=1 with the latched payload held stable.
//   - On bus_addr_ok: go to DATA and drop bus_req in the same edge.
//  DATA:
//   - bus_req=0. Wait for bus_data_ok.
//   - On bus_data_ok: register bus_rdata into the owner's rdata and go to IDLE.
//   - On that edge, pulse the owner's done for exactly 1 cycle, unless discard=1.
//  Arbitration in IDLE:
//   - Only one port requesting: that port is granted.
//   - Both requesting, DATA_PRIO=1: data is granted.
//   - Both requesting, DATA_PRIO=0: the port that is not last_owner is granted.
//   - A port is not re-granted in the cycle its done is high (its req is stale).
//   - last_owner is updated on every grant.
//  Latency:
//   - Minimum 3 cycles from req to done: req@0 -> ADDR@1 (addr_ok@1) -> DATA@2 (data_ok@2) -> done@3.
//   - Bus wait states add cycles 1:1.
//  flush:
//   - In IDLE: suppresses a fetch grant that cycle.
//   - In ADDR or DATA with owner=INST: sets discard. The bus handshake still completes (req is never withdrawn).
//     inst_done stays 0 and inst_rdata is unchanged. discard clears on return to IDLE.
//   - Data transactions are never discarded; the store/load has already committed.
//  Requester drops req mid-transaction: the transaction still completes and the done pulse is still issued.
//  bus_addr_ok and bus_data_ok high in the same cycle in ADDR: ADDR->DATA only. data_ok counts only in DATA.
//  inst_done and data_done are never high in the same cycle.
// STRUCTURE
//  Shared package / header constants:
//   - ARB_IDLE/ARB_ADDR/ARB_DATA state encodings
//   - OWN_INST/OWN_DATA
//   - SIZE_BYTE/SIZE_HALF/SIZE_WORD
//  Payload and rdata registers use the existing flopenrc. No other sub-module; FSM and grant logic are local.
// TESTING
//  1. Fetch only, addr_ok/data_ok immediate, inst_addr=0xBFC00000 -> bus_addr=0xBFC00000, bus_wr=0;
//     inst_done @ cycle 3; inst_rdata = bus_rdata (0x3C1DBFC0).
//  2. Both requesting, DATA_PRIO=1, store 0xDEADBEEF to 0x80000010 size=2 ->
//     data transaction runs first (bus_wr=1, bus_wdata=0xDEADBEEF), then fetch; stall_req high throughout.
//  3. DATA_PRIO=0, both held continuously for 4 transactions -> grants alternate DATA, INST, DATA, INST.
//  4. addr_ok delayed 2 cycles, data_ok delayed 3 cycles -> bus_req stays high with a stable payload; done @ cycle 8.
//  5. flush while fetch is in DATA -> handshake completes, inst_done stays 0, next fetch granted normally.
//  6. rst driven low while in DATA -> all outputs 0 asynchronously; after release, state=IDLE and no stale done.

Source files
------------

// File: rtl/sram_bus_arbiter_pkg.sv
// Shared encodings for the SRAM-like bus arbiter: FSM states, bus owners and access sizes.
package sram_bus_arbiter_pkg;

   typedef enum logic [1:0] {
      ARB_IDLE = 2'd0,
      ARB_ADDR = 2'd1,
      ARB_DATA = 2'd2
   } arbState_t;

   typedef enum logic {
      OWN_INST = 1'b0,
      OWN_DATA = 1'b1
   } owner_t;

   localparam logic [1:0] SIZE_BYTE = 2'd0;
   localparam logic [1:0] SIZE_HALF = 2'd1;
   localparam logic [1:0] SIZE_WORD = 2'd2;

endpackage

// File: rtl/sram_bus_arbiter_flopenrc.sv
// Resettable register with load enable and synchronous clear.
module flopenrc #(
   parameter int unsigned WIDTH = 8
) (
   input  logic             clk,
   input  logic             rst,
   input  logic             en,
   input  logic             clear,
   input  logic [WIDTH-1:0] d,
   output logic [WIDTH-1:0] q
);

   always_ff @(posedge clk or negedge rst) begin
      if (!rst)       q <= '0;
      else if (clear) q <= '0;
      else if (en)    q <= d;
   end

endmodule

// File: rtl/sram_bus_arbiter.sv
// Shares one SRAM-like bus between the fetch port and the MEM-stage load/store port,
// one outstanding transaction at a time, with registered bus outputs.
module sram_bus_arbiter
   import sram_bus_arbiter_pkg::*;
#(
   parameter int unsigned ADDR_W    = 32,
   parameter int unsigned DATA_W    = 32,
   parameter bit          DATA_PRIO = 1'b1
) (
   input  logic              clk,
   input  logic              rst,
   input  logic              inst_req,
   input  logic [ADDR_W-1:0] inst_addr,
   output logic [DATA_W-1:0] inst_rdata,
   output logic              inst_done,
   input  logic              data_req,
   input  logic              data_wr,
   input  logic [1:0]        data_size,
   input  logic [ADDR_W-1:0] data_addr,
   input  logic [DATA_W-1:0] data_wdata,
   output logic [DATA_W-1:0] data_rdata,
   output logic              data_done,
   input  logic              flush,
   output logic              bus_req,
   output logic              bus_wr,
   output logic [1:0]        bus_size,
   output logic [ADDR_W-1:0] bus_addr,
   output logic [DATA_W-1:0] bus_wdata,
   input  logic              bus_addr_ok,
   input  logic              bus_data_ok,
   input  logic [DATA_W-1:0] bus_rdata,
   output logic              stall_req
);

   localparam int unsigned PAY_W = 1 + 2 + ADDR_W + DATA_W;

   arbState_t        state, stateNext;
   owner_t           owner, ownerNext, lastOwner, lastOwnerNext, grantOwner;
   logic             discard, discardNext;
   logic             busReqNext, instDoneNext, dataDoneNext;
   logic             instAvail, dataAvail, grant, payLoad, instLoad, dataLoad;
   logic [PAY_W-1:0] payIn, payQ;

   // A port whose done is high this cycle still shows its old req, so it is not eligible.
   always_comb begin
      instAvail = inst_req & ~inst_done & ~flush;
      dataAvail = data_req & ~data_done;
      grant     = instAvail | dataAvail;
      if (instAvail & dataAvail)
         grantOwner = (DATA_PRIO || lastOwner == OWN_INST) ? OWN_DATA : OWN_INST;
      else
         grantOwner = dataAvail ? OWN_DATA : OWN_INST;
   end

   assign payIn = (grantOwner == OWN_DATA) ? {data_wr, data_size, data_addr, data_wdata}
                                           : {1'b0, SIZE_WORD, inst_addr, {DATA_W{1'b0}}};
   assign payLoad = (state == ARB_IDLE) & grant;

   always_comb begin
      stateNext     = state;
      ownerNext     = owner;
      lastOwnerNext = lastOwner;
      discardNext   = discard;
      busReqNext    = bus_req;
      instDoneNext  = 1'b0;
      dataDoneNext  = 1'b0;
      instLoad      = 1'b0;
      dataLoad      = 1'b0;
      unique case (state)
         ARB_IDLE: begin
            discardNext = 1'b0;
            if (grant) begin
               stateNext     = ARB_ADDR;
               ownerNext     = grantOwner;
               lastOwnerNext = grantOwner;
               busReqNext    = 1'b1;
            end
         end
         ARB_ADDR: begin
            if (flush && owner == OWN_INST) discardNext = 1'b1;
            if (bus_addr_ok) begin
               stateNext  = ARB_DATA;
               busReqNext = 1'b0;
            end
         end
         ARB_DATA: begin
            if (flush && owner == OWN_INST) discardNext = 1'b1;
            if (bus_data_ok) begin
               stateNext   = ARB_IDLE;
               discardNext = 1'b0;
               // A flush arriving together with data_ok also drops the fetch result.
               if (owner == OWN_DATA) begin
                  dataDoneNext = 1'b1;
                  dataLoad     = 1'b1;
               end else if (!(discard || flush)) begin
                  instDoneNext = 1'b1;
                  instLoad     = 1'b1;
               end
            end
         end
         default: stateNext = ARB_IDLE;
      endcase
   end

   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         state     <= ARB_IDLE;
         owner     <= OWN_INST;
         lastOwner <= OWN_INST;
         discard   <= 1'b0;
         bus_req   <= 1'b0;
         inst_done <= 1'b0;
         data_done <= 1'b0;
      end else begin
         state     <= stateNext;
         owner     <= ownerNext;
         lastOwner <= lastOwnerNext;
         discard   <= discardNext;
         bus_req   <= busReqNext;
         inst_done <= instDoneNext;
         data_done <= dataDoneNext;
      end
   end

   flopenrc #(.WIDTH(PAY_W)) payReg (
      .clk(clk), .rst(rst), .en(payLoad), .clear(1'b0), .d(payIn), .q(payQ)
   );
   assign {bus_wr, bus_size, bus_addr, bus_wdata} = payQ;

   flopenrc #(.WIDTH(DATA_W)) instRdataReg (
      .clk(clk), .rst(rst), .en(instLoad), .clear(1'b0), .d(bus_rdata), .q(inst_rdata)
   );

   flopenrc #(.WIDTH(DATA_W)) dataRdataReg (
      .clk(clk), .rst(rst), .en(dataLoad), .clear(1'b0), .d(bus_rdata), .q(data_rdata)
   );

   assign stall_req = (inst_req & ~inst_done) | (data_req & ~data_done);

endmodule
